host_blk_xfer: RTL

//  Block<->word serializer between mem_arb and the host memory-controller interface.
//  - Accepts one 512-bit block request (read fill or write-back) at a time.
//  - Moves it as 16 x 32-bit words over common_data_bus_in/out, with op/io_addr.
//  - Returns the assembled block (read) or a completion (write), with a timeout error flag.

---
 rtl/host_blk_xfer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/host_blk_xfer.sv
// Block<->word serializer: moves one cache block as a burst of host words,
// reassembling reads and issuing a completion (with timeout flag) per request.
module host_blk_xfer #(
  parameter int WORD_SIZE      = 32,
  parameter int BLK_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic                           req_write,
  input  logic [31:0]                    req_addr,
  input  logic [WORD_SIZE*BLK_WORDS-1:0] req_blk,
  output logic                           req_ready,
  output logic                           rsp_valid,
  output logic                           rsp_err,
  output logic [WORD_SIZE*BLK_WORDS-1:0] rsp_blk,
  output logic [2:0]                     op,
  output logic [31:0]                    io_addr,
  output logic [WORD_SIZE-1:0]           common_data_bus_out,
  input  logic [WORD_SIZE-1:0]           common_data_bus_in,
  input  logic                           rd_valid,
  input  logic                           tx_done
);

  localparam int KW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [KW-1:0] K_LAST      = KW'(BLK_WORDS - 1);
  localparam logic [TW-1:0] T_LAST      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   WORD_BYTES  = 32'(WORD_SIZE / 8);
  localparam logic [31:0]   ALIGN_MASK  = ~(32'(WORD_SIZE * BLK_WORDS / 8) - 32'd1);
  localparam logic [2:0]    OP_NOP      = 3'b000;
  localparam logic [2:0]    OP_READ     = 3'b001;
  localparam logic [2:0]    OP_WRITE    = 3'b010;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e                               state_q, state_d;
  logic [KW-1:0]                        k_q, k_d, k_inc;
  logic [TW-1:0]                        tmo_q, tmo_d;
  logic                                 err_q, err_d;
  logic                                 wr_q, wr_d;
  logic [WORD_SIZE-1:0]                 bus_out_q, bus_out_d;
  logic [31:0]                          base_q, base_d;
  logic [BLK_WORDS-1:0][WORD_SIZE-1:0]  blk_q, blk_d;

  assign k_inc = k_q + KW'(1);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    wr_d      = wr_q;
    bus_out_d = bus_out_q;
    base_d    = base_q;
    blk_d     = blk_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr & ALIGN_MASK;
          blk_d   = req_blk;
          k_d     = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          wr_d    = req_write;
          state_d = req_write ? WR : RD;
          bus_out_d = req_write ? req_blk[WORD_SIZE-1:0] : '0;
        end
      end
      RD: begin
        if (rd_valid) begin
          blk_d[k_q] = common_data_bus_in;
          tmo_d      = '0;
          if (k_q == K_LAST) state_d = RESP;
          else               k_d     = k_inc;
        end else if (tmo_q == T_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WR: begin
        if (tx_done) begin
          tmo_d = '0;
          if (k_q == K_LAST) begin
            state_d   = RESP;
            bus_out_d = '0;
          end else begin
            k_d       = k_inc;
            bus_out_d = blk_q[k_inc];
          end
        end else if (tmo_q == T_LAST) begin
          state_d   = RESP;
          err_d     = 1'b1;
          bus_out_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        k_d     = '0;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      bus_out_q <= bus_out_d;
    end
  end

  // Address and block buffer need no reset: every output path masks them by state.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    blk_q  <= blk_d;
  end

  // Outputs decode straight from registered state so reset drops op asynchronously.
  assign req_ready           = (state_q == IDLE);
  assign rsp_valid           = (state_q == RESP);
  assign rsp_err             = (state_q == RESP) && err_q;
  assign rsp_blk             = (state_q == RESP && !wr_q && !err_q) ? blk_q : '0;
  assign op                  = (state_q == RD) ? OP_READ :
                               (state_q == WR) ? OP_WRITE : OP_NOP;
  assign io_addr             = (state_q == RD || state_q == WR) ?
                               base_q + 32'(k_q) * WORD_BYTES : 32'd0;
  assign common_data_bus_out = bus_out_q;

endmodule
